// File: rtl/cb_batch_collector_if.sv
// Callback-FIFO pop port plus batch summary ready/valid port for cb_batch_collector.
// Optional min/max record fields exist only when CB_BATCH_MINMAX_EN is defined.
interface cb_batch_collector_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16
);
   localparam int unsigned SUM_WIDTH = DATA_WIDTH + COUNT_WIDTH;

   logic                   cb_rden_out;
   logic                   cb_empty_in;
   logic [DATA_WIDTH-1:0]  cb_a_in;
   logic                   cb_is_last_in;
   logic                   batch_valid_out;
   logic                   batch_rdy_in;
   logic [SUM_WIDTH-1:0]   batch_sum_out;
   logic [COUNT_WIDTH-1:0] batch_count_out;
   logic [COUNT_WIDTH-1:0] batch_id_out;
   logic                   batch_truncated_out;
`ifdef CB_BATCH_MINMAX_EN
   logic [DATA_WIDTH-1:0]  batch_min_out;
   logic [DATA_WIDTH-1:0]  batch_max_out;
`endif

   modport master (
      output cb_rden_out,
      input  cb_empty_in, cb_a_in, cb_is_last_in,
      output batch_valid_out,
      input  batch_rdy_in,
`ifdef CB_BATCH_MINMAX_EN
      output batch_min_out, batch_max_out,
`endif
      output batch_sum_out, batch_count_out, batch_id_out, batch_truncated_out
   );

   modport slave (
      input  cb_rden_out,
      output cb_empty_in, cb_a_in, cb_is_last_in,
      input  batch_valid_out,
      output batch_rdy_in,
`ifdef CB_BATCH_MINMAX_EN
      input  batch_min_out, batch_max_out,
`endif
      input  batch_sum_out, batch_count_out, batch_id_out, batch_truncated_out
   );
endinterface

// File: rtl/cb_batch_collector.sv
// Pops a show-ahead callback FIFO, accumulates count/sum per batch and emits one summary record.
// Define CB_BATCH_MINMAX_EN to also track unsigned min/max of each batch.
module cb_batch_collector #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16
) (
   input logic                  clk,
   input logic                  rst_n,
   cb_batch_collector_if.master bus
);
   localparam int unsigned SUM_WIDTH = DATA_WIDTH + COUNT_WIDTH;
   // Accumulated count one below saturation: the next pop fills the batch.
   localparam logic [COUNT_WIDTH-1:0] SAT_COUNT = {{(COUNT_WIDTH-1){1'b1}}, 1'b0};

   typedef enum logic {ACCUM = 1'b0, EMIT = 1'b1} state_t;

   state_t                 state;
   logic [SUM_WIDTH-1:0]   acc_sum;
   logic [SUM_WIDTH-1:0]   new_sum;
   logic [COUNT_WIDTH-1:0] acc_count;
   logic [COUNT_WIDTH-1:0] new_count;
   logic [COUNT_WIDTH-1:0] next_id;
   logic                   pop;
   logic                   closing;

   assign pop             = (state == ACCUM) && !bus.cb_empty_in;
   assign bus.cb_rden_out = pop;
   assign new_sum         = acc_sum + SUM_WIDTH'(bus.cb_a_in);
   assign new_count       = acc_count + COUNT_WIDTH'(1);
   assign closing         = bus.cb_is_last_in || (acc_count == SAT_COUNT);

`ifdef CB_BATCH_MINMAX_EN
   logic [DATA_WIDTH-1:0] acc_min;
   logic [DATA_WIDTH-1:0] acc_max;
   logic [DATA_WIDTH-1:0] new_min;
   logic [DATA_WIDTH-1:0] new_max;

   // First pop of a batch (acc_count==0) seeds both trackers.
   assign new_min = ((acc_count == '0) || (bus.cb_a_in < acc_min)) ? bus.cb_a_in : acc_min;
   assign new_max = ((acc_count == '0) || (bus.cb_a_in > acc_max)) ? bus.cb_a_in : acc_max;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_min           <= '0;
         acc_max           <= '0;
         bus.batch_min_out <= '0;
         bus.batch_max_out <= '0;
      end else if (pop) begin
         acc_min <= new_min;
         acc_max <= new_max;
         if (closing) begin
            bus.batch_min_out <= new_min;
            bus.batch_max_out <= new_max;
         end
      end
   end
`endif

   // Batch FSM with registered record outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state                   <= ACCUM;
         acc_sum                 <= '0;
         acc_count               <= '0;
         next_id                 <= '0;
         bus.batch_valid_out     <= 1'b0;
         bus.batch_sum_out       <= '0;
         bus.batch_count_out     <= '0;
         bus.batch_id_out        <= '0;
         bus.batch_truncated_out <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (pop) begin
                  if (closing) begin
                     bus.batch_valid_out     <= 1'b1;
                     bus.batch_sum_out       <= new_sum;
                     bus.batch_count_out     <= new_count;
                     bus.batch_id_out        <= next_id;
                     bus.batch_truncated_out <= !bus.cb_is_last_in;
                     acc_sum                 <= '0;
                     acc_count               <= '0;
                     next_id                 <= next_id + COUNT_WIDTH'(1);
                     state                   <= EMIT;
                  end else begin
                     acc_sum   <= new_sum;
                     acc_count <= new_count;
                  end
               end
            end
            EMIT: begin
               if (bus.batch_rdy_in) begin
                  bus.batch_valid_out <= 1'b0;
                  state               <= ACCUM;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_cb_batch_collector.sv
// Directed bench for cb_batch_collector: a 16-bit-count instance and a 4-bit-count instance
// fed from queue-modelled show-ahead FIFOs; min/max checks compile under CB_BATCH_MINMAX_EN.
`timescale 1ns/1ps
module tb_cb_batch_collector;
   localparam int unsigned DW  = 32;
   localparam int unsigned CWA = 16;
   localparam int unsigned CWB = 4;

   typedef struct {
      logic [DW-1:0] a;
      logic          last;
   } ent_t;

   typedef struct {
      logic [63:0] sum;
      logic [63:0] count;
      logic [63:0] id;
      logic [63:0] trunc;
      logic [63:0] mn;
      logic [63:0] mx;
   } rec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cb_batch_collector_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWA)) ifa ();
   cb_batch_collector_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWB)) ifb ();

   cb_batch_collector #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWA)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.master));
   cb_batch_collector #(.DATA_WIDTH(DW), .COUNT_WIDTH(CWB)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.master));

   ent_t qa[$];
   ent_t qb[$];
   rec_t ra[$];
   rec_t rb[$];
   int   checks      = 0;
   int   failures    = 0;
   int   emit_pops_a = 0;
   int   emit_pops_b = 0;
   logic pop_a, pop_b;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // FIFO model: pop decision sampled at negedge, head re-driven just after the edge.
   always begin
      @(negedge clk);
      pop_a = ifa.cb_rden_out;
      pop_b = ifb.cb_rden_out;
      @(posedge clk);
      #1;
      if (pop_a && qa.size() != 0) void'(qa.pop_front());
      if (pop_b && qb.size() != 0) void'(qb.pop_front());
      ifa.cb_empty_in   = (qa.size() == 0);
      ifa.cb_a_in       = (qa.size() != 0) ? qa[0].a : '0;
      ifa.cb_is_last_in = (qa.size() != 0) ? qa[0].last : 1'b0;
      ifb.cb_empty_in   = (qb.size() == 0);
      ifb.cb_a_in       = (qb.size() != 0) ? qb[0].a : '0;
      ifb.cb_is_last_in = (qb.size() != 0) ? qb[0].last : 1'b0;
   end

   // Record monitor: valid&&rdy at negedge means acceptance on the following edge.
   always @(negedge clk) begin
      if (rst_n && ifa.batch_valid_out && ifa.batch_rdy_in)
         ra.push_back('{64'(ifa.batch_sum_out), 64'(ifa.batch_count_out), 64'(ifa.batch_id_out),
`ifdef CB_BATCH_MINMAX_EN
                        64'(ifa.batch_truncated_out), 64'(ifa.batch_min_out), 64'(ifa.batch_max_out)});
`else
                        64'(ifa.batch_truncated_out), 64'd0, 64'd0});
`endif
      if (rst_n && ifb.batch_valid_out && ifb.batch_rdy_in)
         rb.push_back('{64'(ifb.batch_sum_out), 64'(ifb.batch_count_out), 64'(ifb.batch_id_out),
                        64'(ifb.batch_truncated_out), 64'd0, 64'd0});
      if (ifa.batch_valid_out && ifa.cb_rden_out) emit_pops_a++;
      if (ifb.batch_valid_out && ifb.cb_rden_out) emit_pops_b++;
   end

   task automatic push_a(input int unsigned a, input logic last);
      qa.push_back('{DW'(a), last});
   endtask

   task automatic push_b(input int unsigned a, input logic last);
      qb.push_back('{DW'(a), last});
   endtask

   task automatic set_rdy_a(input logic v);
      @(posedge clk);
      #2 ifa.batch_rdy_in = v;
   endtask

   task automatic wait_rec_a(input string tag, output rec_t r);
      int n = 0;
      while (ra.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_arrived"}, 64'(ra.size() != 0), 1);
      r = (ra.size() != 0) ? ra.pop_front() : '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
   endtask

   task automatic wait_rec_b(input string tag, output rec_t r);
      int n = 0;
      while (rb.size() == 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_arrived"}, 64'(rb.size() != 0), 1);
      r = (rb.size() != 0) ? rb.pop_front() : '{64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
   endtask

   task automatic do_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid", 64'(ifa.batch_valid_out), 0);
      check("rst_count", 64'(ifa.batch_count_out), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      ra.delete();
      rb.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rec_t r, r2;
      logic [63:0] s0, c0, i0;
      int   rem;
      logic ok;
      int   n;

      ifa.batch_rdy_in = 1'b0;
      ifb.batch_rdy_in = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_valid0", 64'(ifa.batch_valid_out), 0);
      check("rst_sum0",   64'(ifa.batch_sum_out), 0);
      check("rst_id0",    64'(ifa.batch_id_out), 0);
      check("rst_trunc0", 64'(ifa.batch_truncated_out), 0);
      check("rst_rden0",  64'(ifa.cb_rden_out), 0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      ifa.batch_rdy_in = 1'b1;
      ifb.batch_rdy_in = 1'b1;

      // Single 0..15 batch
      for (int i = 0; i < 16; i++) push_a(i, i == 15);
      wait_rec_a("b1", r);
      check("b1_sum", r.sum, 120);
      check("b1_count", r.count, 16);
      check("b1_id", r.id, 0);
      check("b1_trunc", r.trunc, 0);

      // Two back-to-back batches after a fresh reset
      do_reset();
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 16; i++) push_a(i, i == 15);
      wait_rec_a("bb0", r);
      wait_rec_a("bb1", r2);
      check("bb0_id", r.id, 0);
      check("bb0_sum", r.sum, 120);
      check("bb0_count", r.count, 16);
      check("bb1_id", r2.id, 1);
      check("bb1_sum", r2.sum, 120);
      check("bb1_count", r2.count, 16);
      check("bb_fifo_drained", 64'(qa.size()), 0);

      // Backpressure: record held 20 cycles with FIFO non-empty
      set_rdy_a(1'b0);
      push_a(5, 1'b0);
      push_a(6, 1'b1);
      push_a(1, 1'b0);
      push_a(2, 1'b0);
      n = 0;
      while (!ifa.batch_valid_out && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("hold_valid", 64'(ifa.batch_valid_out), 1);
      s0  = 64'(ifa.batch_sum_out);
      c0  = 64'(ifa.batch_count_out);
      i0  = 64'(ifa.batch_id_out);
      rem = qa.size();
      check("hold_sum", s0, 11);
      check("hold_count", c0, 2);
      check("hold_id", i0, 2);
      check("hold_rem", 64'(rem), 2);
      ok = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (ifa.batch_valid_out !== 1'b1 || 64'(ifa.batch_sum_out) != s0 ||
             64'(ifa.batch_count_out) != c0 || 64'(ifa.batch_id_out) != i0 ||
             ifa.cb_rden_out !== 1'b0 || qa.size() != rem) ok = 1'b0;
      end
      check("hold_stable", 64'(ok), 1);
      set_rdy_a(1'b1);
      repeat (2) @(negedge clk);
      check("release_valid", 64'(ifa.batch_valid_out), 0);
      check("release_rden", 64'(ifa.cb_rden_out), 1);
      @(negedge clk);
      check("release_popped", 64'(qa.size()), 1);
      wait_rec_a("held", r);
      check("held_sum", r.sum, 11);
      push_a(3, 1'b1);
      wait_rec_a("tail", r);
      check("tail_sum", r.sum, 6);
      check("tail_count", r.count, 3);
      check("tail_id", r.id, 3);

      // Latency: closing pop at edge N, valid seen right after edge N
      push_a(42, 1'b1);
      n = 0;
      while (!ifa.cb_rden_out && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("lat_rden", 64'(ifa.cb_rden_out), 1);
      @(negedge clk);
      check("lat_valid", 64'(ifa.batch_valid_out), 1);
      check("lat_sum", 64'(ifa.batch_sum_out), 42);
      check("lat_count", 64'(ifa.batch_count_out), 1);
      wait_rec_a("lat", r);
      check("lat_id", r.id, 4);

      // Reset mid-batch discards the partial batch and restarts ids
      push_a(7, 1'b0);
      push_a(7, 1'b0);
      push_a(7, 1'b0);
      repeat (6) @(negedge clk);
      check("mid_popped", 64'(qa.size()), 0);
      do_reset();
      push_a(2, 1'b0);
      push_a(3, 1'b1);
      wait_rec_a("postrst", r);
      check("postrst_sum", r.sum, 5);
      check("postrst_count", r.count, 2);
      check("postrst_id", r.id, 0);
      check("postrst_trunc", r.trunc, 0);

`ifdef CB_BATCH_MINMAX_EN
      push_a(9, 1'b0);
      push_a(4, 1'b0);
      push_a(200, 1'b0);
      push_a(17, 1'b1);
      wait_rec_a("mm", r);
      check("mm_min", r.mn, 4);
      check("mm_max", r.mx, 200);
      check("mm_sum", r.sum, 230);
      check("mm_count", r.count, 4);
`endif

      // Count saturation on the 4-bit instance
      for (int i = 1; i <= 20; i++) push_b(1, i == 20);
      wait_rec_b("sat0", r);
      wait_rec_b("sat1", r2);
      check("sat0_count", r.count, 15);
      check("sat0_sum", r.sum, 15);
      check("sat0_trunc", r.trunc, 1);
      check("sat0_id", r.id, 0);
      check("sat1_count", r2.count, 5);
      check("sat1_sum", r2.sum, 5);
      check("sat1_trunc", r2.trunc, 0);
      check("sat1_id", r2.id, 1);

      repeat (4) @(negedge clk);
      check("emit_pops_a", 64'(emit_pops_a), 0);
      check("emit_pops_b", 64'(emit_pops_b), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
